// File: rtl/scmp_sio.sv
// SC/MP serial I/O engine: owns the extension register E and the SIN/SOUT pins.
// Performs single SIO shifts on request and paced, LSB-first 8-bit transfers.
module scmp_sio #(
    parameter int CLKDIV      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e_we,
    input  logic [7:0] e_d,
    output logic [7:0] e_q,
    input  logic       sio_stb,
    input  logic       xfer_start,
    output logic       busy,
    output logic       done,
    input  logic       sin,
    output logic       sout
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKDIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sin_s;
    logic [7:0]             e_r;
    logic                   sout_r;
    logic                   busy_r;
    logic                   done_r;
    logic [2:0]             bit_cnt_r;
    logic [DIV_W-1:0]       div_r;
    logic                   tick_s;
    logic                   last_bit_s;
    logic                   load_s;
    logic                   start_s;
    logic                   shift_s;

    assign sin_s      = sync_r[SYNC_STAGES-1];
    assign tick_s     = (state_r == ST_SHIFT) && (div_r == DIV_MAX);
    assign last_bit_s = tick_s && (bit_cnt_r == 3'd7);

    // Metastability guard: shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sin};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; write requests beat a transfer start in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!e_we && xfer_start) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath controls; requests outside IDLE are dropped.
    always_comb begin
        load_s  = 1'b0;
        start_s = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s  = e_we;
                start_s = !e_we && xfer_start;
                shift_s = !e_we && !xfer_start && sio_stb;
            end
            ST_SHIFT: shift_s = tick_s;
            ST_DONE:  shift_s = 1'b0;
            default:  shift_s = 1'b0;
        endcase
    end

    // E register and SOUT pin: load, or shift in sin_s while the old E[0] goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_r    <= 8'h00;
            sout_r <= 1'b0;
        end else if (load_s) begin
            e_r <= e_d;
        end else if (shift_s) begin
            e_r    <= {sin_s, e_r[7:1]};
            sout_r <= e_r[0];
        end else begin
            e_r    <= e_r;
            sout_r <= sout_r;
        end
    end

    // Bit pacing: divider runs 0..CLKDIV-1, bit counter advances on each wrap.
    always_ff @(posedge clk) begin
        if (rst || start_s) begin
            div_r     <= '0;
            bit_cnt_r <= 3'd0;
        end else if (state_r == ST_SHIFT) begin
            if (tick_s) begin
                div_r     <= '0;
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                div_r <= div_r + DIV_ONE;
            end
        end else begin
            div_r     <= div_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Status flags registered from the next state so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_SHIFT);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign e_q  = e_r;
    assign sout = sout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_scmp_sio.sv
// Self-checking bench for scmp_sio: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the SIO engine.
module tb_scmp_sio;

    localparam int CLKDIV = 4;
    localparam int SS     = 2;
    localparam int P_IDLE = 0;
    localparam int P_XFER = 1;
    localparam int P_DONE = 2;

    logic       clk;
    logic       rst;
    logic       e_we;
    logic [7:0] e_d;
    logic [7:0] e_q;
    logic       sio_stb;
    logic       xfer_start;
    logic       busy;
    logic       done;
    logic       sin;
    logic       sout;

    int n_cmp;
    int n_err;
    int done_cnt;

    // Model state
    logic [7:0] m_e;
    logic       m_sout;
    int         m_ph;
    int         m_t;
    logic       sin_q[$];

    scmp_sio #(.CLKDIV(CLKDIV), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .e_we(e_we), .e_d(e_d), .e_q(e_q),
        .sio_stb(sio_stb), .xfer_start(xfer_start), .busy(busy), .done(done),
        .sin(sin), .sout(sout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic clear_in();
        e_we       = 1'b0;
        sio_stb    = 1'b0;
        xfer_start = 1'b0;
    endtask

    // Model one shift: old bit 0 leaves on sout, synchronized sin enters bit 7.
    task automatic m_shift(input logic s);
        m_sout = m_e[0];
        m_e    = (m_e >> 1) | ({7'd0, s} << 7);
    endtask

    // One clock edge: advance the model with the sampled inputs, then check outputs.
    task automatic tick();
        logic s;
        @(posedge clk);
        s = (sin_q.size() >= SS) ? sin_q[sin_q.size() - SS] : 1'b0;
        if (rst) begin
            sin_q.delete();
            m_e    = 8'h00;
            m_sout = 1'b0;
            m_ph   = P_IDLE;
            m_t    = 0;
        end else begin
            sin_q.push_back(sin);
            if (sin_q.size() > 8) void'(sin_q.pop_front());
            if (m_ph == P_DONE) begin
                m_ph = P_IDLE;
            end else if (m_ph == P_XFER) begin
                m_t++;
                if (m_t % CLKDIV == 0) m_shift(s);
                if (m_t == 8 * CLKDIV) m_ph = P_DONE;
            end else if (e_we) begin
                m_e = e_d;
            end else if (xfer_start) begin
                m_ph = P_XFER;
                m_t  = 0;
            end else if (sio_stb) begin
                m_shift(s);
            end
        end
        #1;
        chk("e_q", {24'd0, e_q}, {24'd0, m_e});
        chk("sout", {31'd0, sout}, {31'd0, m_sout});
        chk("busy", {31'd0, busy}, (m_ph == P_XFER) ? 32'd1 : 32'd0);
        chk("done", {31'd0, done}, (m_ph == P_DONE) ? 32'd1 : 32'd0);
        chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) done_cnt++;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] sbits;
        n_cmp = 0; n_err = 0; done_cnt = 0;
        m_e = 8'h00; m_sout = 1'b0; m_ph = P_IDLE; m_t = 0;
        rst = 1'b1; sin = 1'b0; e_d = 8'h00;
        clear_in();

        // 1. Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            e_we = 1'($urandom); e_d = 8'($urandom); sio_stb = 1'($urandom);
            xfer_start = 1'($urandom); sin = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        clear_in();
        sin = 1'b0;
        tick();
        chk("t1_e", {24'd0, e_q}, 32'h00);
        chk("t1_sout", {31'd0, sout}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_done", {31'd0, done}, 32'd0);

        // 2. Single SIO shifts
        e_we = 1'b1; e_d = 8'hA5; tick(); clear_in();
        sin = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sio_stb = 1'b1; tick(); clear_in();
        chk("t2_e1", {24'd0, e_q}, 32'hD2);
        chk("t2_sout1", {31'd0, sout}, 32'd1);
        sin = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        sio_stb = 1'b1; tick(); clear_in();
        chk("t2_e2", {24'd0, e_q}, 32'h69);
        chk("t2_sout2", {31'd0, sout}, 32'd0);

        // 3. Paced transfer of 0x3C receiving 1,0,1,0,...
        e_we = 1'b1; e_d = 8'h3C; tick(); clear_in();
        pat = 8'h3C;
        xfer_start = 1'b1; tick(); clear_in();
        for (int k = 1; k <= 8; k++) begin
            sin = (k % 2 == 1) ? 1'b1 : 1'b0;
            for (int j = 1; j <= CLKDIV; j++) begin
                tick();
                if (k == 8 && j == CLKDIV) begin
                    chk("t3_done32", {31'd0, done}, 32'd1);
                    chk("t3_busy32", {31'd0, busy}, 32'd0);
                end else begin
                    chk("t3_busy", {31'd0, busy}, 32'd1);
                end
                if (j == CLKDIV) chk("t3_sout", {31'd0, sout}, {31'd0, pat[k-1]});
            end
        end
        chk("t3_final", {24'd0, e_q}, 32'h55);
        tick();
        chk("t3_done_end", {31'd0, done}, 32'd0);

        // 4. Requests during a transfer are ignored
        done_cnt = 0;
        sbits = 8'($urandom);
        xfer_start = 1'b1; tick(); clear_in();
        for (int i = 1; i <= 8 * CLKDIV + 4; i++) begin
            sin = sbits[(i / CLKDIV) % 8];
            if (i == 5)  begin e_we = 1'b1; e_d = 8'hFF; end
            if (i == 9)  sio_stb = 1'b1;
            if (i == 13) xfer_start = 1'b1;
            tick();
            clear_in();
        end
        chk("t4_done_cnt", done_cnt, 32'd1);
        chk("t4_e", {24'd0, e_q}, {24'd0, m_e});

        // 5. Simultaneous requests in IDLE
        e_we = 1'b1; e_d = 8'h80; xfer_start = 1'b1; tick(); clear_in();
        chk("t5_e", {24'd0, e_q}, 32'h80);
        chk("t5_nobusy", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_nobusy2", {31'd0, busy}, 32'd0);
        xfer_start = 1'b1; sio_stb = 1'b1; tick(); clear_in();
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_noshift", {24'd0, e_q}, 32'h80);
        for (int i = 0; i < 8 * CLKDIV + 2; i++) begin
            sin = 1'($urandom);
            tick();
        end

        // 6. Reset after shift 3
        done_cnt = 0;
        xfer_start = 1'b1; tick(); clear_in();
        for (int i = 0; i < 3 * CLKDIV; i++) begin
            sin = 1'($urandom);
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_e", {24'd0, e_q}, 32'h00);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 8 * CLKDIV + 4; i++) tick();
        chk("t6_no_done", done_cnt, 32'd0);
        xfer_start = 1'b1; tick(); clear_in();
        for (int i = 0; i < 8 * CLKDIV + 2; i++) begin
            sin = 1'($urandom);
            tick();
        end
        chk("t6_restart_done", done_cnt, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            e_we       = ($urandom_range(0, 9) == 0);
            e_d        = 8'($urandom);
            xfer_start = ($urandom_range(0, 19) == 0);
            sio_stb    = ($urandom_range(0, 4) == 0);
            sin        = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        clear_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
